// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Run controller that walks the 8-bit core through a fixed list of programs
//   held in instruction ROM. For each program it pulses the fetch unit's Start
//   with the program's start address, counts RUN cycles until the core decodes
//   a halt (or the cycle budget expires), then moves on to the next program.
//
// Parameters
//   NUM_PROGS  : number of programs run in sequence (1..4)
//   START_HOLD : cycles Start is held high per program (>=1)
//   MAX_CYCLES : per-program RUN cycle budget (1..16'hFFFF)
//
// Ports
//   CLK        in   clock, all state on posedge
//   Reset      in   asynchronous active-high reset
//   Go         in   begin the sequence (sampled in IDLE/DONE only)
//   StartAddrs in   start address table, program i at [8i+7:8i]
//   Halt       in   core halt decode (sampled in RUN only)
//   Start      out  fetch Start, registered
//   Start_Addr out  fetch Start_Addr, held from START through RUN
//   ProgIdx    out  index of the active or last program
//   Busy       out  high in START, RUN and NEXT
//   ProgDone   out  one-cycle pulse when a program ends
//   Done       out  high in DONE
//   CycleCount out  RUN cycles of the current or last program
//   TimedOut   out  sticky, set when any program hits MAX_CYCLES

module prog_sequencer #(
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HOLD = 2,
  parameter logic [15:0] MAX_CYCLES = 16'd4096
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   Go,
  input  logic [8*NUM_PROGS-1:0] StartAddrs,
  input  logic                   Halt,
  output logic                   Start,
  output logic [7:0]             Start_Addr,
  output logic [1:0]             ProgIdx,
  output logic                   Busy,
  output logic                   ProgDone,
  output logic                   Done,
  output logic [15:0]            CycleCount,
  output logic                   TimedOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int unsigned HW        = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_PROGS - 1);

  state_e         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           start_q, start_d;
  logic [7:0]     addr_q, addr_d;
  logic [1:0]     idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           pd_q, pd_d;
  logic           done_q, done_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           to_q, to_d;

  logic [31:0]    addr_tbl;
  logic [1:0]     idx_next;
  logic [15:0]    cnt_inc;

  // Table widened to four entries so the next-index lookup never selects
  // outside the vector; unused entries read as zero and are never reached.
  assign addr_tbl = 32'(StartAddrs);
  assign idx_next = idx_q + 2'd1;
  assign cnt_inc  = cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    start_d = start_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    pd_d    = 1'b0;
    cnt_d   = cnt_q;
    to_d    = to_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_d = S_START;
          idx_d   = '0;
          addr_d  = addr_tbl[7:0];
          start_d = 1'b1;
          to_d    = 1'b0;
          hold_d  = '0;
        end
      end

      S_START: begin
        // Halt is ignored here: the PC is still being loaded.
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          start_d = 1'b0;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        // Halt has priority over the budget on the same edge.
        if (Halt || (cnt_inc == MAX_CYCLES)) begin
          pd_d = 1'b1;
          if (!Halt) begin
            to_d = 1'b1;
          end
          state_d = (idx_q == LAST_IDX) ? S_DONE : S_NEXT;
        end
      end

      S_NEXT: begin
        state_d = S_START;
        idx_d   = idx_next;
        addr_d  = addr_tbl[{idx_next, 3'b000} +: 8];
        start_d = 1'b1;
        hold_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_NEXT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      pd_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      pd_q    <= pd_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign Start      = start_q;
  assign Start_Addr = addr_q;
  assign ProgIdx    = idx_q;
  assign Busy       = busy_q;
  assign ProgDone   = pd_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;
  assign TimedOut   = to_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  logic        CLK;
  logic        Reset;
  logic        Go;
  logic        Halt;
  logic [23:0] StartAddrs;
  logic [7:0]  Addrs1;

  logic        Start, Busy, ProgDone, Done, TimedOut;
  logic [7:0]  Start_Addr;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;

  logic        d1_Start, d1_Busy, d1_ProgDone, d1_Done, d1_TimedOut;
  logic [7:0]  d1_Start_Addr;
  logic [1:0]  d1_ProgIdx;
  logic [15:0] d1_CycleCount;

  int passed = 0;
  int total  = 0;
  int pd_cnt = 0;

  prog_sequencer #(
    .NUM_PROGS (3),
    .START_HOLD(2),
    .MAX_CYCLES(16'd16)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Go        (Go),
    .StartAddrs(StartAddrs),
    .Halt      (Halt),
    .Start     (Start),
    .Start_Addr(Start_Addr),
    .ProgIdx   (ProgIdx),
    .Busy      (Busy),
    .ProgDone  (ProgDone),
    .Done      (Done),
    .CycleCount(CycleCount),
    .TimedOut  (TimedOut)
  );

  prog_sequencer #(
    .NUM_PROGS (1),
    .START_HOLD(1),
    .MAX_CYCLES(16'd4096)
  ) dut1 (
    .CLK       (CLK),
    .Reset     (Reset),
    .Go        (Go),
    .StartAddrs(Addrs1),
    .Halt      (Halt),
    .Start     (d1_Start),
    .Start_Addr(d1_Start_Addr),
    .ProgIdx   (d1_ProgIdx),
    .Busy      (d1_Busy),
    .ProgDone  (d1_ProgDone),
    .Done      (d1_Done),
    .CycleCount(d1_CycleCount),
    .TimedOut  (d1_TimedOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (ProgDone === 1'b1) pd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Entered at the first negedge of START. n>0: Halt on the n-th RUN edge;
  // n==0: no halt, program must end on the 16-cycle budget.
  task automatic run_prog(input int idx, input logic [7:0] addr, input int n);
    int highs;
    int runs;
    check("prog_idx", 32'(ProgIdx), idx);
    check("addr_start", 32'(Start_Addr), 32'(addr));
    highs = 0;
    while (Start === 1'b1 && highs < 10) begin
      check("pd_in_start", 32'(ProgDone), 0);
      highs++;
      step();
    end
    check("start_hold", highs, 2);
    check("pd_run_entry", 32'(ProgDone), 0);
    check("cnt_clear", 32'(CycleCount), 0);
    check("addr_run", 32'(Start_Addr), 32'(addr));
    check("busy_run", 32'(Busy), 1);
    if (n > 0) begin
      repeat (n - 1) begin
        step();
        check("pd_early", 32'(ProgDone), 0);
      end
      Halt = 1'b1;
      step();
      Halt = 1'b0;
      check("pd_halt", 32'(ProgDone), 1);
      check("cnt_halt", 32'(CycleCount), n);
    end else begin
      runs = 0;
      do begin
        step();
        runs++;
      end while (ProgDone !== 1'b1 && runs < 40);
      check("timeout_len", runs, 16);
      check("pd_timeout", 32'(ProgDone), 1);
      check("cnt_timeout", 32'(CycleCount), 16);
      check("timedout_set", 32'(TimedOut), 1);
    end
  endtask

  task automatic next_prog();
    check("next_busy", 32'(Busy), 1);
    check("next_start", 32'(Start), 0);
    step();
    check("next_start1", 32'(Start), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pd0;
    StartAddrs = {8'h40, 8'h20, 8'h00};
    Addrs1     = 8'h33;
    Reset = 1'b1;
    Go    = 1'b0;
    Halt  = 1'b0;

    // reset then idle
    repeat (3) step();
    check("rst_outs", {1'b0, Start, Start_Addr, ProgIdx, Busy, ProgDone, Done, CycleCount, TimedOut}, 0);
    Reset = 1'b0;
    repeat (10) begin
      step();
      check("idle_outs", {1'b0, Start, Start_Addr, ProgIdx, Busy, ProgDone, Done, CycleCount, TimedOut}, 0);
    end

    // nominal three-program sequence
    pd0 = pd_cnt;
    Go = 1'b1;
    step();
    Go = 1'b0;
    check("go_busy", 32'(Busy), 1);
    check("go_done", 32'(Done), 0);
    run_prog(0, 8'h00, 5);
    next_prog();
    run_prog(1, 8'h20, 1);
    next_prog();
    run_prog(2, 8'h40, 9);
    check("nom_done", 32'(Done), 1);
    check("nom_idx", 32'(ProgIdx), 2);
    check("nom_busy", 32'(Busy), 0);
    check("nom_to", 32'(TimedOut), 0);
    check("nom_pd_count", pd_cnt - pd0, 3);
    check("p1_done", 32'(d1_Done), 1);
    check("p1_cnt", 32'(d1_CycleCount), 6);
    check("p1_idx", 32'(d1_ProgIdx), 0);
    check("p1_addr", 32'(d1_Start_Addr), 32'h33);
    check("p1_busy", 32'(d1_Busy), 0);
    repeat (2) step();
    check("done_hold", 32'(Done), 1);
    check("cnt_frozen", 32'(CycleCount), 9);

    // halt masking in START, then halt/budget tie
    Halt = 1'b1;
    Go   = 1'b1;
    step();
    Go = 1'b0;
    run_prog(0, 8'h00, 1);
    next_prog();
    run_prog(1, 8'h20, 16);
    check("tie_to", 32'(TimedOut), 0);
    next_prog();
    run_prog(2, 8'h40, 2);
    check("tie_done", 32'(Done), 1);
    check("tie_to_end", 32'(TimedOut), 0);

    // timeout on program 0, then mid-run reset during program 1
    Go = 1'b1;
    step();
    Go = 1'b0;
    run_prog(0, 8'h00, 0);
    check("to_next_busy", 32'(Busy), 1);
    step();
    check("to_cont_idx", 32'(ProgIdx), 1);
    check("to_cont_addr", 32'(Start_Addr), 32'h20);
    check("to_cont_start", 32'(Start), 1);
    repeat (4) step();
    check("pre_rst_busy", 32'(Busy), 1);
    check("pre_rst_to", 32'(TimedOut), 1);
    check("pre_rst_cnt", 32'(CycleCount), 2);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_start", 32'(Start), 0);
    check("arst_busy", 32'(Busy), 0);
    check("arst_idx", 32'(ProgIdx), 0);
    check("arst_cnt", 32'(CycleCount), 0);
    check("arst_to", 32'(TimedOut), 0);
    step();
    Reset = 1'b0;
    step();
    Go = 1'b1;
    step();
    Go = 1'b0;
    run_prog(0, 8'h00, 3);
    next_prog();
    run_prog(1, 8'h20, 0);
    next_prog();
    run_prog(2, 8'h40, 2);
    check("end_done", 32'(Done), 1);
    check("end_idx", 32'(ProgIdx), 2);
    check("end_to", 32'(TimedOut), 1);
    repeat (3) step();
    check("frozen_to", 32'(TimedOut), 1);
    check("frozen_cnt", 32'(CycleCount), 2);

    // rerun from DONE clears TimedOut and Done
    Go = 1'b1;
    step();
    Go = 1'b0;
    check("rerun_to", 32'(TimedOut), 0);
    check("rerun_done", 32'(Done), 0);
    check("rerun_start", 32'(Start), 1);
    check("rerun_addr", 32'(Start_Addr), 0);
    check("rerun_idx", 32'(ProgIdx), 0);
    check("rerun_busy", 32'(Busy), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
